reset_release_sequencer: RTL



---
 rtl/reset_release_sequencer.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/reset_release_sequencer.sv
// -----------------------------------------------------------------------------
// reset_release_sequencer
//
// Purpose:
//   Distributes the board reset to NUM_OUT downstream reset domains. All
//   outputs assert asynchronously with rst_n. Release of rst_n is synchronized
//   to clk, then the outputs are released one at a time, bit 0 first, every
//   STAGE_DLY cycles. An optional software reset, requested through a 4-phase
//   soft_req/soft_ack handshake, re-asserts every output for PULSE_MIN cycles
//   and then re-runs the same staged release.
//
// Configuration:
//   RST_SEQ_SOFT_REQ_EN - when defined, the SOFT_HOLD state, its pulse counter
//   and the soft_req/soft_ack handshake are built. When undefined, soft_req is
//   ignored, soft_ack is tied low and only power-on sequencing exists; the
//   ports are present in both builds.
//
// Parameters:
//   SYNC_STAGES  flops in the reset-release synchronizer (>= 2)
//   NUM_OUT      number of downstream reset outputs (>= 1)
//   STAGE_DLY    cycles between successive releases (>= 1)
//   PULSE_MIN    cycles all outputs stay asserted for a soft reset (>= 1)
//
// Ports:
//   clk           in   single clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   soft_req      in   software reset request (level, synchronous to clk)
//   soft_ack      out  software reset completion acknowledge
//   rst_out_n     out  [NUM_OUT] downstream active-low resets, registered
//   all_released  out  every output released and sequencer in RUN
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module reset_release_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_OUT     = 4,
    parameter int STAGE_DLY   = 8,
    parameter int PULSE_MIN   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               soft_req,
    output logic               soft_ack,
    output logic [NUM_OUT-1:0] rst_out_n,
    output logic               all_released
);

    localparam int CNT_W = $clog2(STAGE_DLY + 1);
    localparam int IDX_W = $clog2(NUM_OUT + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_DLY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OUT - 1);

`ifdef RST_SEQ_SOFT_REQ_EN
    localparam int PULSE_W = $clog2(PULSE_MIN + 1);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_MIN - 1);

    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_RELEASE   = 2'd1,
        ST_RUN       = 2'd2,
        ST_SOFT_HOLD = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;
`endif

    // -------------------------------------------------------------------------
    // Reset-release synchronizer. Assertion is asynchronous through rst_n;
    // only the release is re-timed to clk.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_sync;
    logic                   rst_sync_next;

    // NOTE: every register here is cleared by the asynchronous reset; there are
    // no storage arrays, so nothing is left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops
            // sample their inputs from the same edge.
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync      = sync_q[SYNC_STAGES-1];
    // Value rst_sync will take at the coming edge; HOLD leaves on the edge
    // where rst_sync rises so the first release interval starts there.
    assign rst_sync_next = sync_q[SYNC_STAGES-2];

    // -------------------------------------------------------------------------
    // Sequencer state
    // -------------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_OUT-1:0] rst_out_q, rst_out_d;
    logic               all_rel_q, all_rel_d;

`ifdef RST_SEQ_SOFT_REQ_EN
    logic [PULSE_W-1:0] pulse_q, pulse_d;
    logic               ack_q, ack_d;
    // A soft reset is in flight; its completion raises soft_ack.
    logic               pend_q, pend_d;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;
        all_rel_d = 1'b0;
`ifdef RST_SEQ_SOFT_REQ_EN
        pulse_d   = pulse_q;
        ack_d     = ack_q;
        pend_d    = pend_q;
`endif

        case (state_q)
            ST_HOLD: begin
                rst_out_d = '0;
                if (rst_sync_next || rst_sync) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end

            ST_RELEASE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    for (int i = 0; i < NUM_OUT; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            rst_out_d[i] = 1'b1;
                        end
                    end
                    // idx reaches NUM_OUT after the last release and is not
                    // used again until RELEASE is re-entered with it cleared.
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RUN: begin
                // all_released is registered, so it rises one edge after RUN
                // is entered and drops on the edge that leaves RUN.
                all_rel_d = 1'b1;
`ifdef RST_SEQ_SOFT_REQ_EN
                if (pend_q) begin
                    // Completion of a soft reset: ack rises with all_released.
                    ack_d  = 1'b1;
                    pend_d = 1'b0;
                end else if (soft_req && !ack_q) begin
                    state_d   = ST_SOFT_HOLD;
                    rst_out_d = '0;
                    all_rel_d = 1'b0;
                    pulse_d   = '0;
                    pend_d    = 1'b1;
                end else if (!soft_req) begin
                    ack_d = 1'b0;
                end
`endif
            end

`ifdef RST_SEQ_SOFT_REQ_EN
            ST_SOFT_HOLD: begin
                rst_out_d = '0;
                if (pulse_q == PULSE_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    pulse_d = pulse_q + PULSE_W'(1);
                end
            end
`endif

            default: begin
                state_d   = ST_HOLD;
                rst_out_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_HOLD;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '0;
            all_rel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            all_rel_q <= all_rel_d;
        end
    end

`ifdef RST_SEQ_SOFT_REQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q <= '0;
            ack_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
            ack_q   <= ack_d;
            pend_q  <= pend_d;
        end
    end

    assign soft_ack = ack_q;
`else
    logic unused_soft_req;
    assign unused_soft_req = soft_req;
    assign soft_ack        = 1'b0;
`endif

    assign rst_out_n    = rst_out_q;
    assign all_released = all_rel_q;

endmodule
